nibble_serial_alu16: RTL



---
 rtl/nsalu_pkg.sv | 18 +
 rtl/alu4_slice.sv | 44 ++++
 rtl/nibble_serial_alu16.sv | 135 +++++++++++++
 3 files changed

// File: rtl/nsalu_pkg.sv
// Shared encodings for the nibble-serial ALU: slice opcodes, FSM states, nibble width.
package nsalu_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    OP_OR   = 2'b00,
    OP_ADD  = 2'b01,
    OP_ANDN = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/alu4_slice.sv
// Combinational 4-bit ALU slice: OR, add with carry, and-not, subtract with carry (CO = no borrow).
module alu4_slice
  import nsalu_pkg::*;
(
  input  logic [NIB_W-1:0] r,
  input  logic [NIB_W-1:0] s,
  input  logic             ci,
  input  op_e              i,
  output logic [NIB_W-1:0] f,
  output logic             co,
  output logic             vo,
  output logic             no,
  output logic             zo
);

  logic [NIB_W:0] sum;

  always_comb begin
    sum = '0;
    f   = '0;
    co  = 1'b0;
    vo  = 1'b0;
    case (i)
      OP_OR:   f = r | s;
      OP_ANDN: f = ~r & s;
      OP_ADD: begin
        sum = {1'b0, r} + {1'b0, s} + {{NIB_W{1'b0}}, ci};
        f   = sum[NIB_W-1:0];
        co  = sum[NIB_W];
        vo  = (r[NIB_W-1] == s[NIB_W-1]) && (f[NIB_W-1] != r[NIB_W-1]);
      end
      OP_SUB: begin
        sum = {1'b0, r} + {1'b0, ~s} + {{NIB_W{1'b0}}, ci};
        f   = sum[NIB_W-1:0];
        co  = sum[NIB_W];
        vo  = (r[NIB_W-1] != s[NIB_W-1]) && (f[NIB_W-1] != r[NIB_W-1]);
      end
      default: f = '0;
    endcase
    no = f[NIB_W-1];
    zo = (f == '0);
  end

endmodule

// File: rtl/nibble_serial_alu16.sv
// Nibble-serial W-bit ALU that time-multiplexes one alu4_slice, LS nibble first.
// Build option: define NSALU_SAT_EN for saturating add/subtract.
module nibble_serial_alu16
  import nsalu_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIB_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] f,
  output logic         co,
  output logic         vo,
  output logic         no,
  output logic         zo
);

  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e               state;
  logic [KW-1:0]        k;
  logic                 c;
  op_e                  op_q;
  logic signed [W-1:0]  a_q;
  logic signed [W-1:0]  b_q;
  logic signed [W-1:0]  acc;

  logic [NIB_W-1:0]     sl_f;
  logic                 sl_co, sl_vo, sl_no, sl_zo;
  logic signed [W-1:0]  acc_next;
  logic signed [W-1:0]  f_fin;
  logic                 clamp;
  logic                 no_fin, zo_fin;
  logic                 last;

`ifdef NSALU_SAT_EN
  function automatic logic signed [W-1:0] sat_word(input logic signed [W-1:0] v,
                                                    input logic ovf, input logic neg);
    if (!ovf)    return v;
    else if (neg) return {1'b1, {(W-1){1'b0}}};
    else         return {1'b0, {(W-1){1'b1}}};
  endfunction
`endif

  alu4_slice u_slice (
    .r  (a_q[NIB_W*k +: NIB_W]),
    .s  (b_q[NIB_W*k +: NIB_W]),
    .ci (c),
    .i  (op_q),
    .f  (sl_f),
    .co (sl_co),
    .vo (sl_vo),
    .no (sl_no),
    .zo (sl_zo)
  );

  // Final-pass assembly: the current nibble is merged over the lower nibbles already stored,
  // and the untouched upper nibbles of acc are still zero from the accept.
  always_comb begin
    acc_next = acc;
    acc_next[NIB_W*k +: NIB_W] = sl_f;
    last = (k == KW'(NIBBLES - 1));
`ifdef NSALU_SAT_EN
    clamp = sl_vo;
    f_fin = sat_word(acc_next, sl_vo, a_q[W-1]);
`else
    clamp = 1'b0;
    f_fin = acc_next;
`endif
    no_fin = clamp ? a_q[W-1] : sl_no;
    zo_fin = !clamp && sl_zo && (acc == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      k     <= '0;
      c     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      f     <= '0;
      co    <= 1'b0;
      vo    <= 1'b0;
      no    <= 1'b0;
      zo    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            k     <= '0;
            c     <= ci;
          end
        end
        ST_RUN: begin
          c <= sl_co;
          k <= k + KW'(1);
          if (last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            f     <= f_fin;
            co    <= sl_co;
            vo    <= sl_vo;
            no    <= no_fin;
            zo    <= zo_fin;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand and accumulator registers carry data only; they are reloaded on every accept.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op_e'(op);
      acc  <= '0;
    end else if (state == ST_RUN) begin
      acc <= acc_next;
    end
  end

endmodule
